regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_pkg.sv | 16 +
 rtl/regfile_wr_arbiter_mux.sv | 20 ++
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// write-source encodings and the output-slot state encoding.
package regfile_wr_arbiter_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_wr_arbiter_mux.sv
// Parameterized two-input multiplexer; sel = 1 picks in1.
module regfile_wr_arbiter_mux #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] in0,
   input  logic [SIZE-1:0] in1,
   input  logic            sel,
   output logic [SIZE-1:0] out
);

   // select one of the two inputs
   always_comb begin
      if (sel) begin
         out = in1;
      end else begin
         out = in0;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks onto one registered
// register-file write port; writes to address 0 are accepted and dropped.
module regfile_wr_arbiter #(
   parameter int ADDR_W = regfile_wr_arbiter_pkg::ADDR_W,
   parameter int DATA_W = regfile_wr_arbiter_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready,
   output logic              wr_src,
   output logic [7:0]        conflict_cnt
);

   import regfile_wr_arbiter_pkg::*;

   state_e                    state_r;
   state_e                    state_s;
   logic                      prio_r;
   logic                      grant_s;
   logic                      slot_free_s;
   logic                      xfer_s;
   logic                      load_s;
   logic [ADDR_W+DATA_W-1:0]  sel_payload_s;
   logic [ADDR_W-1:0]         sel_addr_s;
   logic [DATA_W-1:0]         sel_data_s;

   regfile_wr_arbiter_mux #(
      .SIZE (ADDR_W + DATA_W)
   ) u_payload_mux (
      .in0 ({req0_addr, req0_data}),
      .in1 ({req1_addr, req1_data}),
      .sel (grant_s),
      .out (sel_payload_s)
   );

   assign {sel_addr_s, sel_data_s} = sel_payload_s;
   assign wr_en = (state_r == ST_FULL);

   // grant: lone valid requester wins, otherwise the round-robin pointer decides
   always_comb begin
      grant_s = SRC_ALU;
      if (req0_valid && req1_valid) begin
         grant_s = prio_r;
      end else if (req1_valid) begin
         grant_s = SRC_MEM;
      end else begin
         grant_s = SRC_ALU;
      end
   end

   // handshake and slot state transitions; a zero-address transfer never fills the slot
   always_comb begin
      state_s     = state_r;
      slot_free_s = (state_r == ST_EMPTY) || wr_ready;
      xfer_s      = rst_n && slot_free_s && (req0_valid || req1_valid);
      load_s      = xfer_s && (sel_addr_s != {ADDR_W{1'b0}});
      req0_ready  = rst_n && slot_free_s && req0_valid && (grant_s == SRC_ALU);
      req1_ready  = rst_n && slot_free_s && req1_valid && (grant_s == SRC_MEM);
      case (state_r)
         ST_EMPTY: begin
            if (load_s) begin
               state_s = ST_FULL;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (wr_ready && !load_s) begin
               state_s = ST_EMPTY;
            end else begin
               state_s = ST_FULL;
            end
         end
         default: state_s = ST_EMPTY;
      endcase
   end

   // slot register, round-robin pointer and saturating conflict counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_EMPTY;
         prio_r       <= 1'b0;
         wr_addr      <= {ADDR_W{1'b0}};
         wr_data      <= {DATA_W{1'b0}};
         wr_src       <= SRC_ALU;
         conflict_cnt <= 8'd0;
      end else begin
         state_r <= state_s;
         if (xfer_s) begin
            prio_r <= ~grant_s;
         end else begin
            prio_r <= prio_r;
         end
         if (load_s) begin
            wr_addr <= sel_addr_s;
            wr_data <= sel_data_s;
            wr_src  <= grant_s;
         end else begin
            wr_addr <= wr_addr;
            wr_data <= wr_data;
            wr_src  <= wr_src;
         end
         if (req0_valid && req1_valid && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
         end else begin
            conflict_cnt <= conflict_cnt;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected writes are queued at drive
// time and compared when the register file consumes the write port.
module tb_regfile_wr_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int PW = AW + DW + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          wr_en, wr_ready, wr_src;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [7:0]    conflict_cnt;

   logic [PW-1:0] exp_q[$];
   int            n_pass = 0;
   int            n_total = 0;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_addr    (req0_addr),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_addr    (req1_addr),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .wr_src       (wr_src),
      .conflict_cnt (conflict_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
      exp_q.push_back({a, d, s});
   endtask

   // one clock: at the falling edge, a write about to be consumed is scoreboarded
   task automatic tick();
      logic [PW-1:0] e;
      @(negedge clk);
      if (wr_en === 1'b1 && wr_ready === 1'b1) begin
         chk("sb_expected_write", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_write", 64'({wr_addr, wr_data, wr_src}), 64'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      wr_ready   = 1'b0;
   endtask

   initial begin
      // reset holds everything idle even with both requesters asking
      idle_inputs();
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
      req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
      wr_ready = 1'b1;
      @(posedge clk); #1; @(posedge clk); #1;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_wr_src", 64'(wr_src), 64'd0);
      chk("rst_conflict", 64'(conflict_cnt), 64'd0);
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_req1_ready", 64'(req1_ready), 64'd0);
      idle_inputs();
      rst_n = 1'b1;

      // single ALU write with immediate drain
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF; wr_ready = 1'b1;
      #1 chk("a_req0_ready", 64'(req0_ready), 64'd1);
      push(5'd3, 32'hDEADBEEF, 1'b0);
      tick();
      req0_valid = 1'b0;
      chk("a_wr_en", 64'(wr_en), 64'd1);
      chk("a_wr_addr", 64'(wr_addr), 64'd3);
      chk("a_wr_src", 64'(wr_src), 64'd0);
      tick();
      chk("a_wr_en_clear", 64'(wr_en), 64'd0);
      chk("a_q_empty", 64'(exp_q.size()), 64'd0);

      // continuous conflict from reset alternates req0, req1, ...
      rst_n = 1'b0; #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd5;
      req1_valid = 1'b1; req1_addr = 5'd6;
      wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_data = 32'hA000_0000 + 32'(i);
         req1_data = 32'hB000_0000 + 32'(i);
         #1;
         chk("b_req0_ready", 64'(req0_ready), 64'(i % 2 == 0));
         chk("b_req1_ready", 64'(req1_ready), 64'(i % 2 == 1));
         if (i % 2 == 0) push(5'd5, req0_data, 1'b0);
         else            push(5'd6, req1_data, 1'b1);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("b_conflict_cnt", 64'(conflict_cnt), 64'd4);
      tick();
      chk("b_q_empty", 64'(exp_q.size()), 64'd0);

      // back-pressure: slot held stable, req1 stalled until wr_ready
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77; wr_ready = 1'b0;
      push(5'd7, 32'h77, 1'b0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("c_req1_stalled", 64'(req1_ready), 64'd0);
         chk("c_hold", 64'({wr_en, wr_addr, wr_data, wr_src}), 64'({1'b1, 5'd7, 32'h77, 1'b0}));
         tick();
      end
      wr_ready = 1'b1;
      #1 chk("c_req1_ready", 64'(req1_ready), 64'd1);
      push(5'd9, 32'h99, 1'b1);
      tick();
      req1_valid = 1'b0;
      chk("c_refill", 64'({wr_en, wr_addr, wr_src}), 64'({1'b1, 5'd9, 1'b1}));
      tick();
      chk("c_wr_en_clear", 64'(wr_en), 64'd0);

      // zero-address write: accepted, dropped, but still rotates priority
      req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
      push(5'd12, 32'hC, 1'b0);
      tick();
      req0_valid = 1'b0;
      tick();
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
      #1 chk("d_req1_ready", 64'(req1_ready), 64'd1);
      tick();
      req1_valid = 1'b0;
      chk("d_wr_en_stays0", 64'(wr_en), 64'd0);
      req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hD0;
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hD1;
      #1;
      chk("d_grant_req0", 64'({req0_ready, req1_ready}), 64'({1'b1, 1'b0}));
      push(5'd10, 32'hD0, 1'b0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("d_conflict_cnt", 64'(conflict_cnt), 64'd5);
      tick();

      // long conflict run saturates the counter
      req0_valid = 1'b1; req0_addr = 5'd20;
      req1_valid = 1'b1; req1_addr = 5'd21;
      for (int i = 0; i < 300; i++) begin
         req0_data = 32'h0E00_0000 + 32'(i);
         req1_data = 32'h1E00_0000 + 32'(i);
         if (i % 2 == 0) push(5'd21, req1_data, 1'b1);
         else            push(5'd20, req0_data, 1'b0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("e_conflict_sat", 64'(conflict_cnt), 64'd255);
      tick();
      chk("e_conflict_hold", 64'(conflict_cnt), 64'd255);
      chk("e_q_empty", 64'(exp_q.size()), 64'd0);

      // asynchronous reset discards a stalled slot
      wr_ready = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd13; req0_data = 32'h13;
      tick();
      req0_valid = 1'b0;
      chk("f_slot_full", 64'(wr_en), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("f_async_wr_en", 64'(wr_en), 64'd0);
      chk("f_async_conflict", 64'(conflict_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wr_ready = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd14; req0_data = 32'hF0;
      req1_valid = 1'b1; req1_addr = 5'd15; req1_data = 32'hF1;
      #1;
      chk("f_prio_reset", 64'({req0_ready, req1_ready}), 64'({1'b1, 1'b0}));
      chk("f_conflict_zero", 64'(conflict_cnt), 64'd0);
      push(5'd14, 32'hF0, 1'b0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("f_conflict_one", 64'(conflict_cnt), 64'd1);
      tick();
      chk("f_q_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
